// File: rtl/riscv_rf_pkg.sv
// Shared state encoding and write arbitration for the RV12 multi-port register file.
// Arbitration runs on zero-extended addresses so one helper serves any port count up to RF_MAX_WR.
package riscv_rf_pkg;

  localparam int RF_MAX_WR = 8;
  localparam int RF_MAX_AW = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Winning source for one register: debug port, or write port number 'port'.
  typedef struct packed {
    logic       hit;
    logic       dbg;
    logic [2:0] port;
  } rf_win_t;

  // Later (higher-numbered) ports override earlier ones; debug overrides all; x0 never wins.
  function automatic rf_win_t rf_win_sel(
    input logic [RF_MAX_AW-1:0]                addr,
    input logic                                dbg_en,
    input logic [RF_MAX_AW-1:0]                dbg_addr,
    input logic [RF_MAX_WR-1:0]                we,
    input logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] dst
  );
    rf_win_t win;
    win = '0;
    if (addr != '0) begin
      for (int i = 0; i < RF_MAX_WR; i++) begin
        if (we[i] && (dst[i] == addr)) begin
          win.hit  = 1'b1;
          win.dbg  = 1'b0;
          win.port = 3'(i);
        end
      end
      if (dbg_en && (dbg_addr == addr)) begin
        win.hit = 1'b1;
        win.dbg = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/riscv_rf_rdport.sv
// One registered read port: 1-cycle latency, x0 and clear-phase reads forced to zero.
// Bypass data, when offered by the parent, replaces the stored value for this edge.
module riscv_rf_rdport #(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic [AR_BITS-1:0] addr_i,
  input  logic [XLEN-1:0]    rd_dat_i,
  input  logic               byp_vld_i,
  input  logic [XLEN-1:0]    byp_dat_i,
  output logic [XLEN-1:0]    dat_o
);

  logic            zero_q, zero_d;
  logic [XLEN-1:0] dat_q, dat_d;

  always_comb begin
    zero_d = clr_i || (addr_i == '0);
    dat_d  = byp_vld_i ? byp_dat_i : rd_dat_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      zero_q <= 1'b1;
      dat_q  <= '0;
    end else begin
      zero_q <= zero_d;
      dat_q  <= dat_d;
    end
  end

  assign dat_o = zero_q ? '0 : dat_q;

endmodule

// File: rtl/riscv_rf_mp.sv
// RV12 integer register file: RDPORTS read pairs + debug read (1-cycle), WRPORTS write ports, post-reset clear; rf_busy stalls the pipeline.
// Optional read-during-write forwarding under `define RISCV_RF_BYPASS_EN.
module riscv_rf_mp
  import riscv_rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RDPORTS = 2,
  parameter int WRPORTS = 1,
  parameter int AR_BITS = 5
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [RDPORTS-1:0][AR_BITS-1:0] rf_src1,
  input  logic [RDPORTS-1:0][AR_BITS-1:0] rf_src2,
  output logic [RDPORTS-1:0][XLEN-1:0]    rf_srcv1,
  output logic [RDPORTS-1:0][XLEN-1:0]    rf_srcv2,
  input  logic [WRPORTS-1:0][AR_BITS-1:0] rf_dst,
  input  logic [WRPORTS-1:0][XLEN-1:0]    rf_dstv,
  input  logic [WRPORTS-1:0]              rf_we,
  output logic                            rf_busy,
  input  logic                            du_stall,
  input  logic                            du_we_rf,
  input  logic [XLEN-1:0]                 du_dato,
  input  logic [11:0]                     du_addr,
  output logic [XLEN-1:0]                 du_dati_rf
);

  localparam int NREGS = 2 ** AR_BITS;
  localparam int NRD   = 2 * RDPORTS + 1;

  rf_state_e          state_q, state_d;
  logic [AR_BITS-1:0] ptr_q, ptr_d;
  logic [XLEN-1:0]    mem_q [NREGS];
  logic               run;

  logic [RF_MAX_WR-1:0]                we_pad;
  logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] dst_pad;
  logic [RF_MAX_WR-1:0][XLEN-1:0]      dstv_pad;
  logic [RF_MAX_AW-1:0]                du_addr_pad;
  logic                                du_we;
  logic                                unused_du_addr;

  rf_win_t [NREGS-1:0]           mem_win;
  logic    [NREGS-1:0]           mem_we;
  logic    [NREGS-1:0][XLEN-1:0] mem_wd;

  logic [NRD-1:0][AR_BITS-1:0] rd_addr;
  logic [NRD-1:0][XLEN-1:0]    rd_dat;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AR_BITS'(NREGS - 1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= CLEAR;
      ptr_q   <= AR_BITS'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rf_busy = (state_q == CLEAR);
  assign run     = (state_q == RUN) && rstn;

  always_comb begin
    we_pad   = '0;
    dst_pad  = '0;
    dstv_pad = '0;
    for (int w = 0; w < WRPORTS; w++) begin
      we_pad[w]   = rf_we[w] & run;
      dst_pad[w]  = RF_MAX_AW'(rf_dst[w]);
      dstv_pad[w] = rf_dstv[w];
    end
  end

  assign du_we          = du_we_rf & du_stall & run;
  assign du_addr_pad    = RF_MAX_AW'(du_addr[AR_BITS-1:0]);
  assign unused_du_addr = ^du_addr[11:AR_BITS];

  // Per-register winner; the same result feeds storage and forwarding.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_win[i] = rf_win_sel(RF_MAX_AW'(i), du_we, du_addr_pad, we_pad, dst_pad);
      mem_we[i]  = mem_win[i].hit;
      mem_wd[i]  = mem_win[i].dbg ? du_dato : dstv_pad[mem_win[i].port];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (i == 0) begin
        mem_q[i] <= '0;
      end else if (state_q == CLEAR) begin
        if (rstn && (ptr_q == AR_BITS'(i))) mem_q[i] <= '0;
      end else if (mem_we[i]) begin
        mem_q[i] <= mem_wd[i];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < RDPORTS; p++) begin
      rd_addr[p]           = rf_src1[p];
      rd_addr[RDPORTS + p] = rf_src2[p];
    end
    rd_addr[NRD-1] = du_addr[AR_BITS-1:0];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic            byp_vld;
    logic [XLEN-1:0] byp_dat;
`ifdef RISCV_RF_BYPASS_EN
    assign byp_vld = mem_we[rd_addr[k]];
    assign byp_dat = mem_wd[rd_addr[k]];
`else
    assign byp_vld = 1'b0;
    assign byp_dat = '0;
`endif
    riscv_rf_rdport #(
      .XLEN    (XLEN),
      .AR_BITS (AR_BITS)
    ) u_rdport (
      .clk       (clk),
      .rstn      (rstn),
      .clr_i     (rf_busy),
      .addr_i    (rd_addr[k]),
      .rd_dat_i  (mem_q[rd_addr[k]]),
      .byp_vld_i (byp_vld),
      .byp_dat_i (byp_dat),
      .dat_o     (rd_dat[k])
    );
  end

  always_comb begin
    for (int p = 0; p < RDPORTS; p++) begin
      rf_srcv1[p] = rd_dat[p];
      rf_srcv2[p] = rd_dat[RDPORTS + p];
    end
  end

  assign du_dati_rf = rd_dat[NRD-1];

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Randomised bench for riscv_rf_mp (two write ports) against an array-based reference model.
module tb_riscv_rf_mp;

  localparam int XLEN    = 32;
  localparam int RDPORTS = 2;
  localparam int WRPORTS = 2;
  localparam int AR_BITS = 5;
  localparam int NREGS   = 32;
`ifdef RISCV_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                            clk = 1'b0;
  logic                            rstn = 1'b0;
  logic [RDPORTS-1:0][AR_BITS-1:0] rf_src1, rf_src2;
  logic [RDPORTS-1:0][XLEN-1:0]    rf_srcv1, rf_srcv2;
  logic [WRPORTS-1:0][AR_BITS-1:0] rf_dst;
  logic [WRPORTS-1:0][XLEN-1:0]    rf_dstv;
  logic [WRPORTS-1:0]              rf_we;
  logic                            rf_busy;
  logic                            du_stall, du_we_rf;
  logic [XLEN-1:0]                 du_dato, du_dati_rf;
  logic [11:0]                     du_addr;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] mdl [NREGS];
  logic [XLEN-1:0] nxt [NREGS];

  always #5 clk = ~clk;

  riscv_rf_mp #(
    .XLEN(XLEN), .RDPORTS(RDPORTS), .WRPORTS(WRPORTS), .AR_BITS(AR_BITS)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_srcv1(rf_srcv1), .rf_srcv2(rf_srcv2),
    .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we), .rf_busy(rf_busy),
    .du_stall(du_stall), .du_we_rf(du_we_rf), .du_dato(du_dato),
    .du_addr(du_addr), .du_dati_rf(du_dati_rf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rf_we    = '0;
    rf_dst   = '0;
    rf_dstv  = '0;
    du_we_rf = 1'b0;
    du_stall = 1'b0;
    du_dato  = '0;
    du_addr  = '0;
    rf_src1  = '0;
    rf_src2  = '0;
  endtask

  function automatic logic [31:0] seen(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    return BYP ? nxt[a] : mdl[a];
  endfunction

  // Called at a falling edge with inputs set; model the next rising edge and check after it.
  task automatic step();
    logic [31:0] e1 [RDPORTS];
    logic [31:0] e2 [RDPORTS];
    logic [31:0] ed;
    nxt = mdl;
    for (int w = 0; w < WRPORTS; w++)
      if (rf_we[w] && rf_dst[w] != 5'd0) nxt[rf_dst[w]] = rf_dstv[w];
    if (du_we_rf && du_stall && du_addr[4:0] != 5'd0) nxt[du_addr[4:0]] = du_dato;
    for (int p = 0; p < RDPORTS; p++) begin
      e1[p] = seen(rf_src1[p]);
      e2[p] = seen(rf_src2[p]);
    end
    ed = seen(du_addr[4:0]);
    @(posedge clk);
    mdl = nxt;
    @(negedge clk);
    for (int p = 0; p < RDPORTS; p++) begin
      chk($sformatf("srcv1[%0d]", p), rf_srcv1[p], e1[p]);
      chk($sformatf("srcv2[%0d]", p), rf_srcv2[p], e2[p]);
    end
    chk("du_dati", du_dati_rf, ed);
  endtask

  // Counts rising edges from release until rf_busy drops; also checks reads stay 0 meanwhile.
  task automatic wait_clear(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 15) chk("rd_during_clear", rf_srcv1[0], 32'h0);
    end while (rf_busy && n < 100);
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
  endtask

  initial begin
    int n;
    logic [31:0] old7;
    idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_reset", {31'd0, rf_busy}, 32'd1);
    chk("srcv1_reset", rf_srcv1[0], 32'h0);
    chk("srcv2_reset", rf_srcv2[1], 32'h0);
    chk("du_dati_reset", du_dati_rf, 32'h0);

    // Writes presented during clear must be ignored.
    rstn = 1'b1;
    rf_we = 2'b11; rf_dst[0] = 5'd5; rf_dst[1] = 5'd5;
    rf_dstv[0] = 32'h1111_0000; rf_dstv[1] = 32'h2222_0000;
    du_we_rf = 1'b1; du_stall = 1'b1; du_addr = 12'd6; du_dato = 32'h3333_0000;
    rf_src1[0] = 5'd5;
    wait_clear(n);
    chk("clear_len", n, 32'd31);

    // First edge with busy low accepts a write.
    idle();
    rf_we = 2'b01; rf_dst[0] = 5'd9; rf_dstv[0] = 32'h9999_0009;
    rf_src1[0] = 5'd5; rf_src2[0] = 5'd6; du_addr = 12'd6;
    step();
    idle();
    rf_src1[1] = 5'd9;
    step();
    chk("x9_first_write", rf_srcv1[1], 32'h9999_0009);

    for (int i = 1; i < NREGS; i++) begin
      idle();
      rf_src1[0] = 5'(i); rf_src1[1] = 5'(i); rf_src2[0] = 5'(i); rf_src2[1] = 5'(i);
      du_addr = 12'(i);
      step();
    end

    // Same-address priority between write ports, then with debug on top.
    idle();
    rf_we = 2'b11; rf_dst[0] = 5'd5; rf_dst[1] = 5'd5;
    rf_dstv[0] = 32'h0000_AAAA; rf_dstv[1] = 32'h0000_5555;
    step();
    idle(); rf_src1[0] = 5'd5;
    step();
    chk("x5_dual", rf_srcv1[0], 32'h0000_5555);
    idle();
    rf_we = 2'b11; rf_dst[0] = 5'd5; rf_dst[1] = 5'd5;
    rf_dstv[0] = 32'h0000_AAAA; rf_dstv[1] = 32'h0000_5555;
    du_we_rf = 1'b1; du_stall = 1'b1; du_addr = 12'd5; du_dato = 32'h0000_1234;
    step();
    idle(); rf_src2[1] = 5'd5;
    step();
    chk("x5_dbg", rf_srcv2[1], 32'h0000_1234);

    // Read-during-write on x7.
    idle();
    old7 = mdl[7];
    rf_we = 2'b01; rf_dst[0] = 5'd7; rf_dstv[0] = 32'hDEAD_BEEF; rf_src1[0] = 5'd7;
    step();
    chk("x7_rdw", rf_srcv1[0], BYP ? 32'hDEAD_BEEF : old7);
    idle(); rf_src1[0] = 5'd7;
    step();
    chk("x7_after", rf_srcv1[0], 32'hDEAD_BEEF);

    // x0 writes are dropped; du_addr bit 5 is outside the register address.
    idle();
    rf_we = 2'b11; rf_dst[0] = 5'd0; rf_dst[1] = 5'd0;
    rf_dstv[0] = 32'hFFFF_FFFF; rf_dstv[1] = 32'hFFFF_FFFF;
    du_we_rf = 1'b1; du_stall = 1'b1; du_addr = 12'h020; du_dato = 32'hFFFF_FFFF;
    step();
    idle();
    step();
    chk("x0_read", rf_srcv1[0], 32'h0);
    chk("x0_du_read", du_dati_rf, 32'h0);

    // Debug write needs du_stall.
    idle();
    du_we_rf = 1'b1; du_stall = 1'b0; du_addr = 12'd3; du_dato = 32'hCAFE_0003;
    step();
    idle(); rf_src1[0] = 5'd3;
    step();
    chk("x3_nostall", rf_srcv1[0], 32'h0);
    idle();
    du_we_rf = 1'b1; du_stall = 1'b1; du_addr = 12'd3; du_dato = 32'hCAFE_0003;
    step();
    idle(); du_addr = 12'd3;
    step();
    chk("x3_du_read", du_dati_rf, 32'hCAFE_0003);

    for (int t = 0; t < 400; t++) begin
      rf_we    = 2'($urandom);
      du_we_rf = 1'($urandom);
      du_stall = 1'($urandom);
      du_addr  = 12'($urandom);
      du_dato  = $urandom;
      for (int w = 0; w < WRPORTS; w++) begin
        rf_dst[w]  = 5'($urandom_range(0, (t % 2) ? 7 : 31));
        rf_dstv[w] = $urandom;
      end
      for (int p = 0; p < RDPORTS; p++) begin
        rf_src1[p] = 5'($urandom_range(0, (t % 2) ? 7 : 31));
        rf_src2[p] = 5'($urandom_range(0, 31));
      end
      step();
    end

    // Reset reasserted mid-clear restarts the full sequence.
    idle();
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("busy_rst2", {31'd0, rf_busy}, 32'd1);
    rstn = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_midclear", {31'd0, rf_busy}, 32'd1);
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    wait_clear(n);
    chk("clear_len_restart", n, 32'd31);
    for (int i = 1; i < NREGS; i++) begin
      idle();
      rf_src1[0] = 5'(i); rf_src2[1] = 5'(NREGS - i); du_addr = 12'(i);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
